// File: rtl/rca_wb_buffer_if.sv
// Handshake bundle between the custom unit, the writeback buffer and writeback.
// The slave modport is the buffer side and the master modport is the producer/consumer side.
interface rca_wb_buffer_if #(
  parameter int XLEN  = 32,
  parameter int ID_W  = 3,
  parameter int DEPTH = 4
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic            in_valid;
  logic [ID_W-1:0] in_id;
  logic [XLEN-1:0] in_rd;
  logic            in_ready;
  logic            wb_done;
  logic [ID_W-1:0] wb_id;
  logic [XLEN-1:0] wb_rd;
  logic            wb_ack;
  logic [CW-1:0]   count;
  logic            overflow;

  modport slave (
    input  in_valid, in_id, in_rd, wb_ack,
    output in_ready, wb_done, wb_id, wb_rd, count, overflow
  );

  modport master (
    output in_valid, in_id, in_rd, wb_ack,
    input  in_ready, wb_done, wb_id, wb_rd, count, overflow
  );
endinterface

// File: rtl/rca_wb_buffer.sv
// In-order result FIFO toward writeback: one cycle from push to wb_done, or zero cycles when RCA_WB_BYPASS_EN is defined.
// When full, in_ready drops and any result still presented is discarded and recorded in sticky overflow.
module rca_wb_buffer #(
  parameter int XLEN  = 32,
  parameter int ID_W  = 3,
  parameter int DEPTH = 4
) (
  input logic            clk,
  input logic            rst,
  rca_wb_buffer_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int EW = ID_W + XLEN;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  logic [EW-1:0] r_mem [DEPTH];
  logic [AW-1:0] r_head;
  logic [AW-1:0] r_tail;
  logic [CW-1:0] r_count;
  logic          r_overflow;

  logic          w_full;
  logic          w_held;
  logic          w_push;
  logic          w_pop;
  logic [EW-1:0] w_head_ent;

  assign w_full     = (r_count == FULL);
  assign w_held     = (r_count != '0);
  assign w_head_ent = r_mem[r_head];
  assign w_pop      = w_held && bus.wb_ack;

`ifdef RCA_WB_BYPASS_EN
  logic w_bypass;

  // An empty buffer forwards the incoming result; if it is taken right away it never gets stored.
  assign w_bypass = !w_held && bus.in_valid;
  assign w_push   = bus.in_valid && !w_full && !(w_bypass && bus.wb_ack);

  assign bus.wb_done = w_held || w_bypass;
  assign {bus.wb_id, bus.wb_rd} = w_held   ? w_head_ent :
                                  w_bypass ? {bus.in_id, bus.in_rd} : '0;
`else
  assign w_push = bus.in_valid && !w_full;

  assign bus.wb_done = w_held;
  assign {bus.wb_id, bus.wb_rd} = w_held ? w_head_ent : '0;
`endif

  assign bus.in_ready = !w_full;
  assign bus.count    = r_count;
  assign bus.overflow = r_overflow;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_head     <= '0;
      r_tail     <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_push) r_tail <= r_tail + AW'(1);
      if (w_pop)  r_head <= r_head + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
      if (bus.in_valid && w_full) r_overflow <= 1'b1;
    end
  end

  // Storage keeps its contents across reset; the cleared pointers make stale entries unreachable.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_tail] <= {bus.in_id, bus.in_rd};
  end
endmodule

// File: tb/tb_rca_wb_buffer.sv
// Bench for rca_wb_buffer: queue-based reference model compared every cycle plus directed scenario checks.
module tb_rca_wb_buffer;
  localparam int XLEN  = 32;
  localparam int ID_W  = 3;
  localparam int DEPTH = 4;
`ifdef RCA_WB_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;
  bit   chk_en = 1'b0;

  rca_wb_buffer_if #(.XLEN(XLEN), .ID_W(ID_W), .DEPTH(DEPTH)) bus ();

  rca_wb_buffer #(.XLEN(XLEN), .ID_W(ID_W), .DEPTH(DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  // Reference model: an ordered list of stored {id, rd} results plus the sticky flag.
  logic [ID_W+XLEN-1:0] m_q[$];
  bit                   m_ovf;

  always @(posedge clk or posedge rst) begin
    int  sz;
    bit  take;
    if (rst) begin
      m_q.delete();
      m_ovf = 1'b0;
    end else begin
      sz   = m_q.size();
      take = (sz != 0) && bus.wb_ack;
      if (bus.in_valid) begin
        if (sz == DEPTH) m_ovf = 1'b1;
        else if (!(BYP && sz == 0 && bus.wb_ack)) m_q.push_back({bus.in_id, bus.in_rd});
      end
      if (take) void'(m_q.pop_front());
    end
  end

  always @(negedge clk) begin
    int                   sz;
    bit                   byp;
    logic [ID_W+XLEN-1:0] ent;
    if (chk_en) begin
      sz  = m_q.size();
      byp = BYP && sz == 0 && bus.in_valid;
      ent = (sz != 0) ? m_q[0] : byp ? {bus.in_id, bus.in_rd} : '0;
      chk("model_in_ready", 64'(bus.in_ready), 64'(sz != DEPTH));
      chk("model_wb_done",  64'(bus.wb_done),  64'((sz != 0) || byp));
      chk("model_wb_id",    64'(bus.wb_id),    64'(ent[ID_W+XLEN-1:XLEN]));
      chk("model_wb_rd",    64'(bus.wb_rd),    64'(ent[XLEN-1:0]));
      chk("model_count",    64'(bus.count),    64'(sz));
      chk("model_overflow", 64'(bus.overflow), 64'(m_ovf));
    end
  end

  task automatic drive(input bit v, input int id, input logic [XLEN-1:0] rd, input bit ack);
    bus.in_valid = v;
    bus.in_id    = ID_W'(id);
    bus.in_rd    = rd;
    bus.wb_ack   = ack;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    drive(0, 0, '0, 0);
    #1;
    chk("reset_in_ready", 64'(bus.in_ready), 64'd1);
    chk("reset_wb_done",  64'(bus.wb_done),  64'd0);
    chk("reset_count",    64'(bus.count),    64'd0);
    chk("reset_overflow", 64'(bus.overflow), 64'd0);
    tick();
    rst    = 1'b0;
    chk_en = 1'b1;
    tick();

    // Single result with writeback always ready.
    drive(1, 1, 32'h0000_0005, 1);
    if (BYP) begin
      #1;
      chk("byp_done", 64'(bus.wb_done), 64'd1);
      chk("byp_id",   64'(bus.wb_id),   64'd1);
      chk("byp_rd",   64'(bus.wb_rd),   64'd5);
      tick();
      drive(0, 0, '0, 1);
    end else begin
      tick();
      drive(0, 0, '0, 1);
      chk("one_done", 64'(bus.wb_done), 64'd1);
      chk("one_id",   64'(bus.wb_id),   64'd1);
      chk("one_rd",   64'(bus.wb_rd),   64'd5);
      tick();
    end
    chk("one_count_back", 64'(bus.count), 64'd0);

    // Fill to capacity, then overrun.
    for (int i = 0; i < 4; i++) begin
      drive(1, i, 32'(32'h100 + i), 0);
      tick();
    end
    drive(0, 0, '0, 0);
    chk("full_count",    64'(bus.count),    64'd4);
    chk("full_in_ready", 64'(bus.in_ready), 64'd0);
    chk("full_ovf_clr",  64'(bus.overflow), 64'd0);
    drive(1, 4, 32'h104, 0);
    tick();
    drive(0, 0, '0, 0);
    chk("overrun_ovf",   64'(bus.overflow), 64'd1);
    chk("overrun_count", 64'(bus.count),    64'd4);
    chk("overrun_head",  64'(bus.wb_id),    64'd0);

    // Push with ack while full: push dropped, pop still happens.
    drive(1, 5, 32'h105, 1);
    tick();
    drive(0, 0, '0, 0);
    chk("fullack_count", 64'(bus.count),    64'd3);
    chk("fullack_head",  64'(bus.wb_id),    64'd1);
    chk("fullack_rd",    64'(bus.wb_rd),    64'h101);
    chk("fullack_ovf",   64'(bus.overflow), 64'd1);

    // Asynchronous reset in the middle of a cycle with three entries held.
    #2;
    rst = 1'b1;
    #1;
    chk("arst_done",  64'(bus.wb_done),  64'd0);
    chk("arst_count", 64'(bus.count),    64'd0);
    chk("arst_ovf",   64'(bus.overflow), 64'd0);
    chk("arst_ready", 64'(bus.in_ready), 64'd1);
    tick();
    rst = 1'b0;
    drive(1, 7, 32'h77, 0);
    tick();
    drive(0, 0, '0, 0);
    chk("post_rst_id",    64'(bus.wb_id),   64'd7);
    chk("post_rst_rd",    64'(bus.wb_rd),   64'h77);
    chk("post_rst_count", 64'(bus.count),   64'd1);

    // Steady state at count 2: push and pop every cycle across pointer wrap.
    drive(1, 0, 32'h100, 0);
    tick();
    for (int k = 1; k <= 10; k++) begin
      drive(1, k, 32'(32'h100 + k), 1);
      tick();
      chk("stream_count", 64'(bus.count), 64'd2);
    end
    drive(0, 0, '0, 0);
    chk("stream_head_id", 64'(bus.wb_id), 64'd1);
    chk("stream_head_rd", 64'(bus.wb_rd), 64'h109);

    // Drain, then ack on an empty buffer.
    drive(0, 0, '0, 1);
    tick();
    tick();
    chk("drain_count", 64'(bus.count), 64'd0);
    tick();
    chk("idle_ack_count", 64'(bus.count),   64'd0);
    chk("idle_ack_done",  64'(bus.wb_done), 64'd0);
    drive(0, 0, '0, 0);
    tick();

    chk_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/rca_wb_buffer.md
RCA_WB_BUFFER -- requirements
Module: rca_wb_buffer

Interface
REQ-001 The block SHALL take parameter XLEN, default 32, as the result data width.
REQ-002 The block SHALL take parameter ID_W, default 3, as the instruction-id width.
REQ-003 The block SHALL take parameter DEPTH, default 4, as the entry count; it is a power of two and at least 2.
REQ-004 The block SHALL have port clk, input, 1 bit: clock; all state updates on the rising edge.
REQ-005 The block SHALL have port rst, input, 1 bit: reset, asynchronous, active-high.
REQ-006 The block SHALL have port in_valid, input, 1 bit: the custom unit presents a result this cycle.
REQ-007 The block SHALL have port in_id, input, ID_W bits: instruction id of the presented result.
REQ-008 The block SHALL have port in_rd, input, XLEN bits: presented result value.
REQ-009 The block SHALL have port in_ready, output, 1 bit: the buffer accepts a result this cycle.
REQ-010 The block SHALL have port wb_done, output, 1 bit: a result is offered to writeback.
REQ-011 The block SHALL have port wb_id, output, ID_W bits: id of the offered result.
REQ-012 The block SHALL have port wb_rd, output, XLEN bits: offered result value.
REQ-013 The block SHALL have port wb_ack, input, 1 bit: writeback consumes the offered result this cycle.
REQ-014 The block SHALL have port count, output, $clog2(DEPTH)+1 bits: number of stored entries.
REQ-015 The block SHALL have port overflow, output, 1 bit: sticky flag, set when a result was presented while in_ready was 0.

Function
REQ-016 The buffer SHALL be a FIFO with head/tail pointers of $clog2(DEPTH) bits that wrap from DEPTH-1 to 0.
REQ-017 A push SHALL occur when in_valid and in_ready are both 1: {in_id, in_rd} is written at tail, tail increments and count increments.
REQ-018 in_ready SHALL equal (count != DEPTH) and SHALL NOT depend on wb_ack.
REQ-019 wb_done SHALL equal (count != 0); wb_id and wb_rd SHALL show the head entry combinationally, and 0 when wb_done is 0.
REQ-020 A pop SHALL occur when wb_done and wb_ack are both 1: head increments and count decrements.
REQ-021 wb_ack while wb_done is 0 SHALL be ignored.
REQ-022 A simultaneous push and pop SHALL leave count unchanged and advance both pointers, including at count == 1 and count == DEPTH-1.
REQ-023 With the Configuration feature compiled out, a result SHALL first appear on wb_done one cycle after its push edge.
REQ-024 Results SHALL leave in push order; ids SHALL NOT be reordered or altered.
REQ-025 in_valid while in_ready is 0 SHALL drop the result, leave state unchanged and set overflow to 1 on that edge.
REQ-026 overflow SHALL remain 1 until reset.

Reset
REQ-027 On rst high, regardless of clk, the block SHALL clear head, tail, count and overflow to 0, drive wb_done to 0 and in_ready to 1.
REQ-028 Storage contents SHALL NOT be reset.
REQ-029 Entries held when reset asserts mid-operation SHALL be discarded and never offered.

Configuration
REQ-030 With macro RCA_WB_BYPASS_EN defined, when count == 0 and in_valid is 1, the block SHALL drive wb_done = 1 and wb_id/wb_rd = in_id/in_rd in the same cycle.
REQ-031 Under bypass, if wb_ack is also 1 that cycle, the result SHALL be consumed without being written and count SHALL stay 0; otherwise it is pushed normally.
REQ-032 With RCA_WB_BYPASS_EN undefined, no combinational path SHALL exist from in_valid, in_id or in_rd to any wb_* output.

Verification
REQ-033 The bench SHALL cover: push id=1, rd=0x0000_0005, wb_ack held 1 -> wb_done=1, wb_id=1, wb_rd=5 the next cycle (same cycle with bypass); count returns to 0.
REQ-034 The bench SHALL cover: 4 pushes (ids 0..3) with wb_ack=0 -> count=4, in_ready=0; a fifth push sets overflow=1 and count stays 4.
REQ-035 The bench SHALL cover: count=4, then push id=5 plus ack in one cycle -> in_ready=0, so id=5 is dropped, overflow=1, count=3, head id=1.
REQ-036 The bench SHALL cover: count=2, then push plus ack for 10 consecutive cycles -> count stays 2, pointers wrap, output ids stay in push order.
REQ-037 The bench SHALL cover: count=3, then assert rst mid-cycle -> wb_done=0, count=0, overflow=0 immediately; after release, the next push id=7 is the first offered.
REQ-038 The bench SHALL cover: wb_ack=1 with count=0 and in_valid=0 -> no change and count stays 0.
